mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/response controller wrapped around a fixed-latency, non-stallable
// multiplier. Accepted requests travel down a tracking pipe that runs in step
// with the multiplier. Their results land in an in-order result FIFO.
// Admission is limited by an occupancy count of in-flight plus stored results,
// so the FIFO can never overflow even though the multiplier cannot stall.
module mul_issue_ctrl #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [63:0]      req_op1_i,
  input  logic [63:0]      req_op2_i,
  input  logic             req_word_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [63:0]      mul_op1_o,
  output logic [63:0]      mul_op2_o,
  input  logic [63:0]      mul_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [63:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Stage 0 rides alongside the operand registers.
  // Stages 1..LATENCY follow the multiplier.
  // The tail stage LATENCY is valid in the cycle its product is on mul_result_i.
  logic [LATENCY:0]  r_stg_valid;
  logic [LATENCY:0]  r_stg_word;
  logic [TAG_W-1:0]  r_stg_tag [0:LATENCY];

  logic [63:0]       r_op1;
  logic [63:0]       r_op2;

  logic [63:0]       r_mem_data [0:DEPTH-1];
  logic [TAG_W-1:0]  r_mem_tag  [0:DEPTH-1];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic [CNT_W-1:0]  r_occ;

  logic              w_accept;
  logic              w_pop;
  logic              w_wr;
  logic [63:0]       w_wr_data;
  logic [63:0]       w_op1_cond;
  logic [63:0]       w_op2_cond;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake terms.
  // Ready depends only on registered occupancy, so a pop in the same cycle
  // cannot raise it. It is forced low while reset is held.
  always_comb begin
    req_ready_o = ~rst && (r_occ < CNT_W'(DEPTH));
    w_accept    = req_valid_i && req_ready_o;
    rsp_valid_o = (r_fifo_cnt != '0);
    w_pop       = rsp_valid_o && rsp_ready_i;
    w_wr        = r_stg_valid[LATENCY];
  end

  // Operand conditioning: MULW uses only the low words, sign-extended.
  // The result write path applies the same conditioning to the low word of
  // the product.
  always_comb begin
    w_op1_cond = req_word_i ? sext32(req_op1_i[31:0]) : req_op1_i;
    w_op2_cond = req_word_i ? sext32(req_op2_i[31:0]) : req_op2_i;
    w_wr_data  = r_stg_word[LATENCY] ? sext32(mul_result_i[31:0]) : mul_result_i;
  end

  // Operand registers feeding the multiplier; they change only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (w_accept) begin
      r_op1 <= w_op1_cond;
      r_op2 <= w_op2_cond;
    end
  end

  assign mul_op1_o = r_op1;
  assign mul_op2_o = r_op2;

  // Tracking pipe.
  // It advances every cycle because the multiplier never stalls.
  // A bubble enters as valid=0. Word/tag load unconditionally, because valid
  // qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_valid <= '0;
      r_stg_word  <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        r_stg_tag[i] <= '0;
      end
    end else begin
      r_stg_valid <= {r_stg_valid[LATENCY-1:0], w_accept};
      r_stg_word  <= {r_stg_word[LATENCY-1:0], req_word_i};
      r_stg_tag[0] <= req_tag_i;
      for (int i = 1; i <= LATENCY; i++) begin
        r_stg_tag[i] <= r_stg_tag[i-1];
      end
    end
  end

  // Result FIFO storage.
  // It is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
    end else if (w_wr) begin
      r_mem_data[r_wr_ptr] <= w_wr_data;
      r_mem_tag[r_wr_ptr]  <= r_stg_tag[LATENCY];
    end
  end

  // FIFO pointers and stored-entry count, with wrap-around for any DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_wr, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Occupancy counts in-flight plus stored results.
  // Capping it at DEPTH reserves a FIFO slot for every product already issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign rsp_data_o = r_mem_data[r_rd_ptr];
  assign rsp_tag_o  = r_mem_tag[r_rd_ptr];

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomised and directed bench for mul_issue_ctrl.
// A queue-based model predicts ready, valid, head data/tag and operand
// registers every cycle. A delay line stands in for the downstream multiplier.
module tb_mul_issue_ctrl;

  localparam int L  = 3;
  localparam int TW = 5;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [63:0]   req_op1_i = '0;
  logic [63:0]   req_op2_i = '0;
  logic          req_word_i = 1'b0;
  logic [TW-1:0] req_tag_i = '0;
  logic [63:0]   mul_op1_o;
  logic [63:0]   mul_op2_o;
  logic [63:0]   mul_result_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [63:0]   rsp_data_o;
  logic [TW-1:0] rsp_tag_o;

  mul_issue_ctrl #(.LATENCY(L), .TAG_W(TW), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .req_word_i   (req_word_i),
    .req_tag_i    (req_tag_i),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_result_i (mul_result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_tag_o    (rsp_tag_o)
  );

  always #5 clk = ~clk;

  // Downstream multiplier: product of the operands seen in a cycle, L cycles later.
  logic [63:0] prod [1:L];
  always @(posedge clk) begin
    prod[1] <= mul_op1_o * mul_op2_o;
    for (int k = 2; k <= L; k++) prod[k] <= prod[k-1];
  end
  assign mul_result_i = prod[L];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pops     = 0;

  typedef struct {
    logic [63:0]   data;
    logic [TW-1:0] tag;
    int            avail;
  } exp_t;
  exp_t q[$];
  exp_t e_new;
  logic ev;
  logic [63:0] eop1 = '0;
  logic [63:0] eop2 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] cond(input logic [63:0] v, input logic w);
    logic [31:0] lo;
    lo = v[31:0];
    return w ? {{32{lo[31]}}, lo} : v;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input logic w);
    logic signed [63:0] x;
    logic signed [63:0] y;
    logic signed [63:0] p;
    x = $signed(cond(a, w));
    y = $signed(cond(b, w));
    p = x * y;
    return cond(p, w);
  endfunction

  // Model and per-cycle compare.
  // A request accepted in cycle c is visible from cycle c+L+2, in order.
  // Occupancy is the number accepted and not yet popped.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      eop1 = '0;
      eop2 = '0;
      chk("rst_ready", 64'(req_ready_o), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst_rsp_data", rsp_data_o, 64'(0));
      chk("rst_rsp_tag", 64'(rsp_tag_o), 64'(0));
      chk("rst_op1", mul_op1_o, 64'(0));
      chk("rst_op2", mul_op2_o, 64'(0));
    end else begin
      ev = (q.size() > 0) && (q[0].avail <= cyc);
      chk("ready", 64'(req_ready_o), 64'(q.size() < D));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(ev));
      if (ev) begin
        chk("rsp_data", rsp_data_o, q[0].data);
        chk("rsp_tag", 64'(rsp_tag_o), 64'(q[0].tag));
      end
      chk("mul_op1", mul_op1_o, eop1);
      chk("mul_op2", mul_op2_o, eop2);
      if (ev && rsp_ready_i) begin
        void'(q.pop_front());
        pops++;
      end
      if (req_valid_i && req_ready_o) begin
        e_new.data  = ref_mul(req_op1_i, req_op2_i, req_word_i);
        e_new.tag   = req_tag_i;
        e_new.avail = cyc + L + 2;
        q.push_back(e_new);
        eop1 = cond(req_op1_i, req_word_i);
        eop2 = cond(req_op2_i, req_word_i);
      end
    end
  end

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  // One isolated request; hand-computed expectations for operand and response timing.
  task automatic do_single(input logic [63:0] a, input logic [63:0] b, input logic w,
                           input logic [TW-1:0] t, input logic [63:0] exp_data,
                           input logic [63:0] exp_op1);
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_op1_i = a; req_op2_i = b; req_word_i = w; req_tag_i = t;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) chk("lit_op1", mul_op1_o, exp_op1);
      chk("lit_valid", 64'(rsp_valid_o), 64'(k == 5));
      if (k == 5) begin
        chk("lit_data", rsp_data_o, exp_data);
        chk("lit_tag", 64'(rsp_tag_o), 64'(t));
      end
    end
  endtask

  int drops;
  int acc;
  int p0;

  initial begin
    #32 rst = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready_o), 64'(1));

    do_single(-64'sd3, 64'sd7, 1'b0, TW'(5), 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD);
    do_single(64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, TW'(9), 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_7FFF_FFFF);
    do_single(64'hDEAD_BEEF_8000_0000, 64'd3, 1'b1, TW'(1), 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000);

    // Back-to-back random traffic with the consumer always ready.
    drops = 0;
    p0 = pops;
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_op1_i   = rnd64();
      req_op2_i   = rnd64();
      req_word_i  = 1'($urandom_range(0, 1));
      req_tag_i   = TW'($urandom_range(0, 31));
      @(negedge clk);
      if (!req_ready_o) drops++;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    wait_drain();
    chk("b2b_ready_drops", 64'(drops), 64'(0));
    chk("b2b_resp_count", 64'(pops - p0), 64'(1024));

    // Back-pressure: fill to DEPTH, then release.
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    acc = 0;
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      req_valid_i = 1'b1;
      req_op1_i   = rnd64();
      req_op2_i   = rnd64();
      req_word_i  = 1'($urandom_range(0, 1));
      req_tag_i   = TW'(10 + i);
      @(negedge clk);
      if (req_ready_o) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepts", 64'(acc), 64'(8));
    chk("bp_ready_low", 64'(req_ready_o), 64'(0));
    chk("bp_valid_high", 64'(rsp_valid_o), 64'(1));
    chk("bp_head_tag", 64'(rsp_tag_o), 64'(10));
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_at_first_pop", 64'(req_ready_o), 64'(0));
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(req_ready_o), 64'(1));
    wait_drain();
    chk("bp_pop_count", 64'(pops - p0), 64'(8));

    // Reset with three in flight and two stored.
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      req_op1_i   = rnd64();
      req_op2_i   = rnd64();
      req_word_i  = 1'($urandom_range(0, 1));
      req_tag_i   = TW'(20 + i);
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_valid", 64'(rsp_valid_o), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_imm_valid", 64'(rsp_valid_o), 64'(0));
    chk("rst_imm_ready", 64'(req_ready_o), 64'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(rsp_valid_o), 64'(0));
    end
    do_single(64'd6, 64'd7, 1'b0, TW'(3), 64'd42, 64'd6);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cycle %0d got running expected finished", cyc);
    $fatal(1);
  end

endmodule
